instruction_loader: RTL

- Streaming writer for the 4096 x 19-bit instruction store. It is the write-side counterpart of the read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word count, then 3 bytes per instruction.
- Assembles each 19-bit instruction and issues single-cycle write strobes at sequential addresses.
- Sits between the host/UART byte source and the write port of the instruction RAM. Used to load programs at runtime instead of only at simulation init.

---
 rtl/instruction_loader_if.sv | 28 ++
 rtl/instruction_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-RAM write-port bundle for instruction_loader.
// The loader uses the slave modport; the host / byte source uses master.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 19
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [7:0]            in_byte;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, base_addr, in_byte, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, base_addr, in_byte, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/instruction_loader.sv
// Streaming writer for the instruction store: 16-bit big-endian word count,
// then 3 big-endian bytes per instruction, one write strobe per word.
module instruction_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 19
) (
  input logic                clk,
  input logic                rst_n,
  instruction_loader_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, DONE
  } state_t;

  state_t                r_state;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_remaining;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-17:0] r_b0;
  logic [7:0]            r_b1;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic [15:0]           w_count;
  logic                  w_count_bad;
  logic                  w_b0_bad;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_count     = {r_len_hi, bus.in_byte};
  assign w_count_bad = (w_count == 16'd0) || (32'(w_count) > (32'd1 << ADDR_WIDTH));
  // Any B0 bit at or above position DATA_WIDTH-16 lies outside the instruction
  assign w_b0_bad    = |(bus.in_byte >> (DATA_WIDTH - 16));
  assign w_word      = {r_b0, r_b1, bus.in_byte};

  // Outputs are registered: each transition loads the values of the state it enters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len_hi    <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_addr     <= bus.base_addr;
          r_error    <= 1'b0;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b1;
          r_state    <= LEN_HI;
        end
        LEN_HI: if (w_accept) begin
          r_len_hi <= bus.in_byte;
          r_state  <= LEN_LO;
        end
        LEN_LO: if (w_accept) begin
          if (w_count_bad) begin
            r_error    <= 1'b1;
            r_in_ready <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_remaining <= w_count;
            r_state     <= B0;
          end
        end
        B0: if (w_accept) begin
          if (w_b0_bad) begin
            r_error    <= 1'b1;
            r_in_ready <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_b0    <= bus.in_byte[DATA_WIDTH-17:0];
            r_state <= B1;
          end
        end
        B1: if (w_accept) begin
          r_b1    <= bus.in_byte;
          r_state <= B2;
        end
        B2: if (w_accept) begin
          r_in_ready <= 1'b0;
          r_wr_en    <= 1'b1;
          r_wr_addr  <= r_addr;
          r_wr_data  <= w_word;
          r_state    <= WRITE;
        end
        WRITE: begin
          r_addr      <= r_addr + ADDR_WIDTH'(1);
          r_remaining <= r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= B0;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.error    = r_error;
endmodule
